// File: rtl/clken_synth_pkg.sv
// Shared FSM encoding, defaults and settle-counter sizing for clken_synth.
// Constants only; no latency or backpressure.
package clken_synth_pkg;

   typedef enum logic [1:0] {
      ST_STDBY  = 2'd0,
      ST_SETTLE = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int NCH_DEF      = 2;
   localparam int ACC_W_DEF    = 16;
   localparam int LOCK_CYC_DEF = 64;
   localparam int INC_DEF_DEF  = 43691;

   // Counter must hold 0..LOCK_CYC
   function automatic int settle_cnt_w(input int lock_cyc);
      return $clog2(lock_cyc + 1);
   endfunction

   localparam int SETTLE_CNT_W_DEF = settle_cnt_w(LOCK_CYC_DEF);

endpackage

// File: rtl/clken_synth_acc.sv
// One synthesiser channel: phase accumulator with carry-driven clken and MSB clkout.
// clken/clkout registered one cycle after the add; no backpressure.
module clken_acc
   import clken_synth_pkg::*;
#(
   parameter int ACC_W   = ACC_W_DEF,
   parameter int INC_DEF = INC_DEF_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [ACC_W-1:0] wr_inc,
   input  logic [ACC_W-1:0] wr_ph,
   input  logic             load,
   input  logic             run,
   input  logic             out_en,
   output logic             clken,
   output logic             clkout
);

   logic [ACC_W-1:0] inc_q;
   logic [ACC_W-1:0] ph_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] ph_eff;
   logic [ACC_W-1:0] acc_nxt;
   logic [ACC_W:0]   sum;
   logic             carry;

   always_comb begin
      // A write coinciding with a reload must seed the accumulator with the new phase
      ph_eff  = wr ? wr_ph : ph_q;
      sum     = {1'b0, acc_q} + {1'b0, inc_q};
      acc_nxt = acc_q;
      carry   = 1'b0;
      if (load) begin
         acc_nxt = ph_eff;
      end else if (run) begin
         acc_nxt = sum[ACC_W-1:0];
         carry   = sum[ACC_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inc_q  <= ACC_W'(INC_DEF);
         ph_q   <= '0;
         acc_q  <= '0;
         clken  <= 1'b0;
         clkout <= 1'b0;
      end else begin
         if (wr) begin
            inc_q <= wr_inc;
            ph_q  <= wr_ph;
         end
         acc_q  <= acc_nxt;
         clken  <= out_en & carry;
         clkout <= out_en & acc_nxt[ACC_W-1];
      end
   end

endmodule

// File: rtl/clken_synth.sv
// Multi-channel clock-enable synthesiser with standby/settle/lock sequencing.
// Outputs registered; extlock follows LOCK_CYC settle cycles; no backpressure.
module clken_synth
   import clken_synth_pkg::*;
#(
   parameter int NCH      = NCH_DEF,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int LOCK_CYC = LOCK_CYC_DEF,
   parameter int INC_DEF  = INC_DEF_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stdby,
   input  logic             restart,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_ch,
   input  logic [ACC_W-1:0] cfg_inc,
   input  logic [ACC_W-1:0] cfg_ph,
   output logic [NCH-1:0]   clken,
   output logic [NCH-1:0]   clkout,
   output logic             extlock
);

   localparam int CNT_W = settle_cnt_w(LOCK_CYC);

   state_t           state_q;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cfg_hit;
   logic             load;
   logic             run;
   logic             out_en;

   assign cfg_hit = cfg_we && (32'(cfg_ch) < NCH);

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      load      = 1'b0;
      if (stdby) begin
         state_nxt = ST_STDBY;
      end else if (state_q == ST_STDBY || restart || cfg_hit) begin
         // Standby release, restart and live reconfiguration share one SETTLE entry
         state_nxt = ST_SETTLE;
         cnt_nxt   = '0;
         load      = 1'b1;
      end else if (state_q == ST_SETTLE) begin
         if (cnt_q == CNT_W'(LOCK_CYC - 1)) begin
            state_nxt = ST_LOCKED;
         end
         cnt_nxt = cnt_q + CNT_W'(1);
      end
   end

   assign run    = (state_q != ST_STDBY);
   assign out_en = (state_nxt == ST_LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_SETTLE;
         cnt_q   <= '0;
         extlock <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         extlock <= out_en;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      clken_acc #(
         .ACC_W   (ACC_W),
         .INC_DEF (INC_DEF)
      ) u_acc (
         .clk    (clk),
         .rst_n  (rst_n),
         .wr     (cfg_we && (32'(cfg_ch) == i)),
         .wr_inc (cfg_inc),
         .wr_ph  (cfg_ph),
         .load   (load),
         .run    (run),
         .out_en (out_en),
         .clken  (clken[i]),
         .clkout (clkout[i])
      );
   end

endmodule

// File: tb/tb_clken_synth.sv
// Directed bench for clken_synth (NCH=2, ACC_W=16, LOCK_CYC=64).
module tb_clken_synth;

   logic        clk;
   logic        rst_n;
   logic        stdby;
   logic        restart;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_inc;
   logic [15:0] cfg_ph;
   logic [1:0]  clken;
   logic [1:0]  clkout;
   logic        extlock;

   int checks = 0;
   int errors = 0;

   clken_synth #(
      .NCH      (2),
      .ACC_W    (16),
      .LOCK_CYC (64),
      .INC_DEF  (43691)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .stdby   (stdby),
      .restart (restart),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_inc (cfg_inc),
      .cfg_ph  (cfg_ph),
      .clken   (clken),
      .clkout  (clkout),
      .extlock (extlock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of edges until extlock is seen, or -1 on timeout
   task automatic wait_lock(output int n, output int early);
      n = -1;
      early = 0;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (extlock) begin
            n = i;
            break;
         end
         if (clken != 2'b00) early = 1;
      end
   endtask

   task automatic count_pulses(input int cyc, output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < cyc; i++) begin
         tick();
         c0 += int'(clken[0]);
         c1 += int'(clken[1]);
      end
   endtask

   // Bit i holds the value i cycles after the current sample point
   task automatic sample8(output logic [7:0] ce0, output logic [7:0] ce1, output logic [7:0] co1);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         ce0[i] = clken[0];
         ce1[i] = clken[1];
         co1[i] = clkout[1];
      end
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [15:0] inc, input logic [15:0] ph,
                            input logic rs);
      cfg_we  = 1'b1;
      cfg_ch  = ch;
      cfg_inc = inc;
      cfg_ph  = ph;
      restart = rs;
      tick();
      cfg_we  = 1'b0;
      restart = 1'b0;
   endtask

   initial begin
      int n, early, c0, c1, any;
      logic [7:0] ce0, ce1, co1;

      rst_n   = 1'b0;
      stdby   = 1'b0;
      restart = 1'b0;
      cfg_we  = 1'b0;
      cfg_ch  = 2'd0;
      cfg_inc = 16'd0;
      cfg_ph  = 16'd0;
      #3;
      chk("reset_extlock", int'(extlock), 0);
      chk("reset_clken", int'(clken), 0);
      chk("reset_clkout", int'(clkout), 0);

      // Reset release with stdby low: lock after 64 edges, nothing before it
      tick();
      rst_n = 1'b1;
      wait_lock(n, early);
      chk("lock_after_reset", n, 64);
      chk("no_clken_before_lock", early, 0);
      count_pulses(3000, c0, c1);
      chk("ch0_default_rate", int'(c0 >= 1999 && c0 <= 2001), 1);

      // Live write of ch1: drop lock, relock, then quarter-rate pattern
      cfg_write(2'd1, 16'h4000, 16'h0000, 1'b0);
      chk("write_drops_lock", int'(extlock), 0);
      wait_lock(n, early);
      chk("relock_after_write", n, 64);
      sample8(ce0, ce1, co1);
      chk("ch1_clken_quarter", int'(ce1), 'h11);
      chk("ch1_clkout_2hi_2lo", int'(co1), 'hCC);

      // ch0 write, then ch1 write together with restart: one reload using new phase
      cfg_write(2'd0, 16'h4000, 16'h0000, 1'b0);
      cfg_write(2'd1, 16'h4000, 16'h8000, 1'b1);
      wait_lock(n, early);
      chk("relock_after_restart", n, 64);
      sample8(ce0, ce1, co1);
      chk("align_ch0", int'(ce0), 'h11);
      chk("align_ch1_leads_2", int'(ce1), 'h44);

      // Standby: outputs cleared next cycle, restart ignored while held
      stdby = 1'b1;
      tick();
      chk("stdby_extlock", int'(extlock), 0);
      chk("stdby_clken", int'(clken), 0);
      chk("stdby_clkout", int'(clkout), 0);
      any = 0;
      for (int i = 0; i < 20; i++) begin
         restart = (i == 5);
         tick();
         if (extlock || clken != 2'b00 || clkout != 2'b00) any = 1;
      end
      restart = 1'b0;
      chk("stdby_holds_quiet", any, 0);
      stdby = 1'b0;
      tick();
      chk("stdby_release_settling", int'(extlock), 0);
      wait_lock(n, early);
      chk("lock_after_stdby", n, 64);
      sample8(ce0, ce1, co1);
      chk("stdby_align_ch0", int'(ce0), 'h11);
      chk("stdby_align_ch1", int'(ce1), 'h44);

      // Out-of-range channel write changes nothing
      cfg_write(2'd3, 16'h0000, 16'h1234, 1'b0);
      chk("bad_ch_keeps_lock", int'(extlock), 1);
      count_pulses(40, c0, c1);
      chk("bad_ch_ch0_rate", c0, 10);
      chk("bad_ch_ch1_rate", c1, 10);

      // inc=0 silences ch0 while ch1 keeps running
      cfg_write(2'd0, 16'h0000, 16'h0000, 1'b0);
      wait_lock(n, early);
      chk("relock_inc0", n, 64);
      count_pulses(1000, c0, c1);
      chk("ch0_inc0_silent", c0, 0);
      chk("ch1_still_running", c1, 250);

      // Asynchronous reset mid-lock, away from any clock edge
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_extlock", int'(extlock), 0);
      chk("async_rst_clken", int'(clken), 0);
      chk("async_rst_clkout", int'(clkout), 0);
      tick();
      rst_n = 1'b1;
      wait_lock(n, early);
      chk("lock_after_async_rst", n, 64);
      count_pulses(3000, c0, c1);
      chk("ch0_inc_restored", int'(c0 >= 1999 && c0 <= 2001), 1);
      chk("ch1_inc_restored", int'(c1 >= 1999 && c1 <= 2001), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
